// File: rtl/snake_rand_pos_pkg.sv
// Shared constants, FSM state type and cell-index helper for the snake random position generator.
package snake_rand_pkg;

    localparam logic [15:0] LFSR_POLY   = 16'hB400;
    localparam logic [15:0] SEED_STRIDE = 16'h9E37;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } draw_state_e;

    function automatic int unsigned cell_idx(input int unsigned row, input int unsigned col,
                                             input int unsigned grid_w);
        return row * grid_w + col;
    endfunction

endpackage

// File: rtl/snake_rand_pos_if.sv
// Request/result bundle between the game-control FSM (master) and the position generator (slave).
interface snake_rand_pos_if #(
    parameter int N_CH = 2,
    parameter int PW   = 7
);
    logic [N_CH-1:0]    req;
    logic [N_CH-1:0]    excl_en;
    logic [N_CH*PW-1:0] excl_pos;
    logic [N_CH-1:0]    busy;
    logic [N_CH-1:0]    valid;
    logic [N_CH*PW-1:0] pos;
    logic [N_CH-1:0]    fallback;

    modport master (
        output req, excl_en, excl_pos,
        input  busy, valid, pos, fallback
    );

    modport slave (
        input  req, excl_en, excl_pos,
        output busy, valid, pos, fallback
    );
endinterface

// File: rtl/snake_rand_pos_lfsr16.sv
// 16-bit Galois LFSR; a load takes priority over a step and a zero load value is replaced by 1.
module snake_lfsr16
    import snake_rand_pkg::*;
#(
    parameter logic [15:0] INIT = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic [15:0] state_o
);
    localparam logic [15:0] INIT_NZ = (INIT == 16'h0000) ? 16'h0001 : INIT;

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (load_val_i == 16'h0000) ? 16'h0001 : load_val_i;
        end else if (step_i) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_NZ;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/snake_rand_pos.sv
// N_CH-channel rejection-sampling cell generator for the Snake playfield.
// Optional SNAKE_RAND_SEED_LOAD_EN adds seed_load/seed_val ports for deterministic replay.
module snake_rand_pos
    import snake_rand_pkg::*;
#(
    parameter int          N_CH      = 2,
    parameter int          GRID_W    = 10,
    parameter int          GRID_H    = 10,
    parameter int          MARGIN    = 1,
    parameter int          MAX_TRIES = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SNAKE_RAND_SEED_LOAD_EN
    input  logic [N_CH-1:0]   seed_load,
    input  logic [15:0]       seed_val,
`endif
    snake_rand_pos_if.slave   rp
);
    localparam int PW = $clog2(GRID_W * GRID_H);
    localparam int CW = $clog2(GRID_W);
    localparam int RW = $clog2(GRID_H);

    localparam logic [0:0]    S_IDLE       = 1'(IDLE);
    localparam logic [0:0]    S_DRAW       = 1'(DRAW);
    localparam logic [7:0]    TRY_LAST     = 8'(MAX_TRIES - 1);
    localparam logic [PW-1:0] FALLBACK_POS = PW'(cell_idx(MARGIN, MARGIN, GRID_W));

    if (CW + RW > 16) begin : g_err_fields
        $error("snake_rand_pos: candidate fields do not fit in the 16-bit LFSR");
    end
    if (2 * MARGIN >= GRID_W || 2 * MARGIN >= GRID_H) begin : g_err_margin
        $error("snake_rand_pos: MARGIN leaves no interior cells");
    end

    logic [N_CH-1:0]    busy_v;
    logic [N_CH-1:0]    valid_v;
    logic [N_CH-1:0]    fb_v;
    logic [N_CH*PW-1:0] pos_v;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [15:0]   lfsr;
            logic          lfsr_load;
            logic [15:0]   lfsr_load_val;
            logic          lfsr_unused;
            logic [CW-1:0] col;
            logic [RW-1:0] row;
            logic [31:0]   col_w;
            logic [31:0]   row_w;
            logic [PW-1:0] cand;
            logic          accept;

            logic [0:0]    state_q, state_d;
            logic [7:0]    tries_q, tries_d;
            logic          valid_q, valid_d;
            logic [PW-1:0] pos_q, pos_d;
            logic          fb_q, fb_d;

`ifdef SNAKE_RAND_SEED_LOAD_EN
            assign lfsr_load     = seed_load[gi];
            assign lfsr_load_val = seed_val;
`else
            assign lfsr_load     = 1'b0;
            assign lfsr_load_val = 16'h0000;
`endif

            snake_lfsr16 #(
                .INIT(SEED ^ (16'(gi) * SEED_STRIDE))
            ) u_lfsr (
                .clk        (clk),
                .rst_n      (rst_n),
                .step_i     (1'b1),
                .load_i     (lfsr_load),
                .load_val_i (lfsr_load_val),
                .state_o    (lfsr)
            );

            // Only the low CW+RW bits form the candidate; the rest just keep the sequence long.
            assign lfsr_unused = ^lfsr;
            assign col   = lfsr[CW-1:0];
            assign row   = lfsr[CW+RW-1:CW];
            assign col_w = 32'(col);
            assign row_w = 32'(row);
            assign cand  = PW'(cell_idx(row_w, col_w, GRID_W));

            assign accept = (col_w >= 32'(MARGIN)) && (col_w < 32'(GRID_W - MARGIN)) &&
                            (row_w >= 32'(MARGIN)) && (row_w < 32'(GRID_H - MARGIN)) &&
                            !(rp.excl_en[gi] && (cand == rp.excl_pos[gi*PW +: PW]));

            always_comb begin
                state_d = state_q;
                tries_d = tries_q;
                valid_d = 1'b0;
                pos_d   = pos_q;
                fb_d    = fb_q;
                if (state_q == S_IDLE) begin
                    if (rp.req[gi]) begin
                        state_d = S_DRAW;
                        tries_d = 8'd0;
                    end
                end else if (accept) begin
                    pos_d   = cand;
                    valid_d = 1'b1;
                    fb_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (tries_q == TRY_LAST) begin
                    // Fallback cell is returned even if it equals the excluded cell.
                    pos_d   = FALLBACK_POS;
                    valid_d = 1'b1;
                    fb_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tries_d = tries_q + 8'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= S_IDLE;
                    tries_q <= 8'd0;
                    valid_q <= 1'b0;
                    pos_q   <= '0;
                    fb_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    tries_q <= tries_d;
                    valid_q <= valid_d;
                    pos_q   <= pos_d;
                    fb_q    <= fb_d;
                end
            end

            assign busy_v[gi]            = (state_q == S_DRAW);
            assign valid_v[gi]           = valid_q;
            assign fb_v[gi]              = fb_q;
            assign pos_v[gi*PW +: PW]    = pos_q;
        end
    endgenerate

    assign rp.busy     = busy_v;
    assign rp.valid    = valid_v;
    assign rp.fallback = fb_v;
    assign rp.pos      = pos_v;
endmodule

// File: tb/tb_snake_rand_pos.sv
// Scoreboard bench: stimulus predicts each draw from an LFSR model, monitors pop and compare on valid.
module tb_snake_rand_pos;

    typedef struct {
        int pos;
        int fb;
        int edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t qa0[$];
    exp_t qa1[$];
    exp_t qb[$];

    logic [15:0] ma0 = 16'hACE1;
    logic [15:0] ma1 = 16'h32D6;
    logic [15:0] mb  = 16'hACE1;

    snake_rand_pos_if #(.N_CH(2), .PW(7)) ifa ();
    snake_rand_pos_if #(.N_CH(1), .PW(7)) ifb ();

`ifdef SNAKE_RAND_SEED_LOAD_EN
    logic [1:0]  sla = 2'b00;
    logic [0:0]  slb = 1'b0;
    logic [15:0] sv  = 16'h0000;
`endif

    snake_rand_pos #(.N_CH(2), .GRID_W(10), .GRID_H(10), .MARGIN(1), .MAX_TRIES(16), .SEED(16'hACE1)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SNAKE_RAND_SEED_LOAD_EN
        .seed_load (sla),
        .seed_val  (sv),
`endif
        .rp    (ifa)
    );

    snake_rand_pos #(.N_CH(1), .GRID_W(10), .GRID_H(10), .MARGIN(4), .MAX_TRIES(1), .SEED(16'hACE1)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SNAKE_RAND_SEED_LOAD_EN
        .seed_load (slb),
        .seed_val  (sv),
`endif
        .rp    (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        logic [15:0] n;
        logic        b;
        b = v[0];
        for (int i = 0; i < 15; i++) n[i] = v[i+1];
        n[15] = b;
        n[13] = n[13] ^ b;
        n[12] = n[12] ^ b;
        n[10] = n[10] ^ b;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma0 <= 16'hACE1;
            ma1 <= 16'h32D6;
            mb  <= 16'hACE1;
        end else begin
            ma0 <= lstep(ma0);
            ma1 <= lstep(ma1);
            mb  <= lstep(mb);
        end
    end

    // a = model LFSR value in the cycle before the request edge; 10x10 grid, 4-bit col/row fields.
    task automatic predict(input logic [15:0] a, input int mg, input int mt, input bit xen,
                           input int xp, output int lat, output int p, output int fb);
        logic [15:0] v;
        int col, row, c;
        bit found;
        v = a;
        found = 0;
        fb = 1;
        p = mg * 10 + mg;
        lat = mt;
        for (int j = 1; j <= mt; j++) begin
            v = lstep(v);
            col = int'(v[3:0]);
            row = int'(v[7:4]);
            c = row * 10 + col;
            if (!found && col >= mg && col < 10 - mg && row >= mg && row < 10 - mg &&
                !(xen && c == xp)) begin
                found = 1;
                fb = 0;
                p = c;
                lat = j;
            end
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input string nm, inout exp_t q[$], input int p, input int fb);
        exp_t e;
        if (q.size() == 0) begin
            check({nm, "_unexpected_valid"}, 1, 0);
        end else begin
            e = q.pop_front();
            check({nm, "_pos"}, p, e.pos);
            check({nm, "_fallback"}, fb, e.fb);
            check({nm, "_edge"}, cyc, e.edge_no);
            $display("%s pos=%0d fb=%0d edge=%0d", nm, p, fb, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.valid[0]) begin
                pop_cmp("a0", qa0, int'(ifa.pos[6:0]), int'(ifa.fallback[0]));
                if (ifa.excl_en[0] && !ifa.fallback[0])
                    check("a0_excluded_cell_returned", int'(ifa.pos[6:0] == ifa.excl_pos[6:0]), 0);
            end
            if (ifa.valid[1]) pop_cmp("a1", qa1, int'(ifa.pos[13:7]), int'(ifa.fallback[1]));
            if (ifb.valid[0]) pop_cmp("b0", qb, int'(ifb.pos[6:0]), int'(ifb.fallback[0]));
        end
    end

    task automatic issue_a(input int k);
        exp_t e;
        int lat, p, fb, n;
        n = cyc + 1;
        if (k == 0) predict(ma0, 1, 16, ifa.excl_en[0], int'(ifa.excl_pos[6:0]), lat, p, fb);
        else        predict(ma1, 1, 16, ifa.excl_en[1], int'(ifa.excl_pos[13:7]), lat, p, fb);
        e.pos = p; e.fb = fb; e.edge_no = n + lat;
        if (k == 0) qa0.push_back(e); else qa1.push_back(e);
        ifa.req[k] = 1'b1;
        @(negedge clk);
        ifa.req[k] = 1'b0;
        while (cyc < e.edge_no) begin
            check("a_busy_in_draw", int'(ifa.busy[k]), 1);
            @(negedge clk);
        end
        check("a_busy_after_valid", int'(ifa.busy[k]), 0);
    endtask

    task automatic issue_b();
        exp_t e;
        int lat, p, fb;
        predict(mb, 4, 1, 1'b0, 0, lat, p, fb);
        e.pos = p; e.fb = fb; e.edge_no = cyc + 1 + lat;
        qb.push_back(e);
        ifb.req[0] = 1'b1;
        @(negedge clk);
        ifb.req[0] = 1'b0;
        check("b_busy_in_draw", int'(ifb.busy[0]), 1);
        @(negedge clk);
        check("b_busy_after_valid", int'(ifb.busy[0]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int last_s[2];
        int last_e;
        int lat, p, fb, n;
        logic [15:0] av;
        exp_t e;

        ifa.req = 2'b11; ifa.excl_en = 2'b00; ifa.excl_pos = '0;
        ifb.req = 1'b1;  ifb.excl_en = 1'b0;  ifb.excl_pos = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(ifa.busy), 0);
        check("rst_valid", int'(ifa.valid), 0);
        check("rst_pos", int'(ifa.pos), 0);
        check("rst_fallback", int'(ifa.fallback), 0);
        check("rst_b_busy", int'(ifb.busy), 0);
        ifa.req = 2'b00;
        ifb.req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) issue_a(0);
        for (int i = 0; i < 3; i++) issue_a(1);

        ifa.excl_en[0] = 1'b1;
        ifa.excl_pos[6:0] = 7'd44;
        for (int i = 0; i < 40; i++) issue_a(0);
        ifa.excl_en[0] = 1'b0;

        for (int i = 0; i < 12; i++) issue_b();

        // Both channels held high: chain of back-to-back draws, one IDLE edge between them.
        last_e = 0;
        for (int k = 0; k < 2; k++) begin
            av = (k == 0) ? ma0 : ma1;
            n = cyc + 1;
            while (n <= cyc + 101) begin
                predict(av, 1, 16, 1'b0, 0, lat, p, fb);
                e.pos = p; e.fb = fb; e.edge_no = n + lat;
                if (k == 0) qa0.push_back(e); else qa1.push_back(e);
                last_s[k] = n;
                if (e.edge_no > last_e) last_e = e.edge_no;
                for (int s = 0; s <= lat; s++) av = lstep(av);
                n = n + lat + 1;
            end
        end
        ifa.req = 2'b11;
        while (cyc <= last_e) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) if (cyc == last_s[k]) ifa.req[k] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Async reset while channel 0 is mid-draw: no result may ever appear for it.
        ifa.req[0] = 1'b1;
        @(negedge clk);
        ifa.req[0] = 1'b0;
        check("mid_busy_before_rst", int'(ifa.busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(ifa.busy), 0);
        check("mid_rst_valid", int'(ifa.valid), 0);
        check("mid_rst_pos", int'(ifa.pos), 0);
        check("mid_rst_fallback", int'(ifa.fallback), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue_a(0);
        issue_b();
        repeat (2) @(negedge clk);

        check("a0_pending", qa0.size(), 0);
        check("a1_pending", qa1.size(), 0);
        check("b0_pending", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
